// File: rtl/iq_interp_upsampler_pkg.sv
// rtl/iq_interp_upsampler_pkg.sv - shared FSM encoding, defaults and width helper for the I/Q upsampler
package iq_interp_upsampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_RUN   = 3'b010,
        ST_DRAIN = 3'b100
    } state_t;

    localparam int DEF_LOG2_OSR = 3;
    localparam int DEF_IN_W     = 11;
    localparam int DEF_OUT_W    = 11;

    // Width of (cur-prev)*phase: one bit for the difference plus the phase bits.
    function automatic int interp_w(input int in_w, input int log2_osr);
        return in_w + 1 + log2_osr;
    endfunction

endpackage

// File: rtl/iq_interp_upsampler_interp_lerp.sv
// rtl/iq_interp_upsampler_interp_lerp.sv - per-rail prev/cur symbol registers and linear interpolator
module interp_lerp
    import iq_interp_upsampler_pkg::*;
#(
    parameter int LOG2_OSR = DEF_LOG2_OSR,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       en,
    input  logic                       capture,
    input  logic                       force_zero,
    input  logic [LOG2_OSR-1:0]        phase,
    input  logic signed [IN_W-1:0]     sym,
    output logic signed [OUT_W-1:0]    dac
);

    localparam int PW = interp_w(IN_W, LOG2_OSR);

    logic signed [IN_W-1:0] prev_q;
    logic signed [IN_W-1:0] cur_q;
    logic signed [IN_W-1:0] prev_e;
    logic signed [IN_W-1:0] cur_e;
    logic signed [IN_W:0]   diff;
    logic signed [IN_W:0]   step;
    logic signed [IN_W:0]   sum;
    logic signed [PW-1:0]   prod;

    // On a capture cycle the phase-0 sample already uses the newly loaded pair.
    always_comb begin
        prev_e = prev_q;
        cur_e  = cur_q;
        if (capture) begin
            prev_e = force_zero ? '0 : cur_q;
            cur_e  = force_zero ? '0 : sym;
        end
        diff = (IN_W+1)'(cur_e) - (IN_W+1)'(prev_e);
        prod = PW'(diff) * PW'($signed({1'b0, phase}));
        step = (IN_W+1)'(prod >>> LOG2_OSR);
        sum  = (IN_W+1)'(prev_e) + step;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q <= '0;
            cur_q  <= '0;
            dac    <= '0;
        end else if (en) begin
            if (capture) begin
                prev_q <= prev_e;
                cur_q  <= cur_e;
            end
            dac <= OUT_W'($signed(sum[IN_W-1:0]));
        end
    end

endmodule

// File: rtl/iq_interp_upsampler.sv
// rtl/iq_interp_upsampler.sv - symbol-rate enable generator and OSR linear-interpolating I/Q upsampler
module iq_interp_upsampler
    import iq_interp_upsampler_pkg::*;
#(
    parameter int LOG2_OSR = DEF_LOG2_OSR,
    parameter int IN_W     = DEF_IN_W,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    output logic                    ce_sym,
    input  logic signed [IN_W-1:0]  xr_i,
    input  logic signed [IN_W-1:0]  xi_i,
    input  logic                    valid_i,
    output logic signed [OUT_W-1:0] dac_i,
    output logic signed [OUT_W-1:0] dac_q,
    output logic                    valid_o
);

    localparam logic [LOG2_OSR-1:0] PH_LAST = '1;
    localparam logic [LOG2_OSR-1:0] PH_ONE  = LOG2_OSR'(1);

    logic [LOG2_OSR-1:0]    phase_q;
    state_t                 state_q;
    state_t                 st_n;
    logic                   capture;
    logic                   force_zero;
    logic signed [IN_W-1:0] sym_i;
    logic signed [IN_W-1:0] sym_q;

    assign capture = en && (phase_q == '0);
    assign ce_sym  = en && (phase_q == PH_LAST);

    always_comb begin
        st_n = ST_IDLE;
        case (state_q)
            ST_IDLE:  st_n = valid_i ? ST_RUN : ST_IDLE;
            ST_RUN:   st_n = valid_i ? ST_RUN : ST_DRAIN;
            ST_DRAIN: st_n = valid_i ? ST_RUN : ST_IDLE;
            default:  st_n = ST_IDLE;
        endcase
    end

    // Landing in IDLE clears both rails so an idle output is exactly zero.
    assign force_zero = capture && (st_n == ST_IDLE);
    assign sym_i      = valid_i ? xr_i : '0;
    assign sym_q      = valid_i ? xi_i : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase_q <= '0;
            state_q <= ST_IDLE;
            valid_o <= 1'b0;
        end else if (en) begin
            phase_q <= phase_q + PH_ONE;
            if (capture) begin
                state_q <= st_n;
            end
            valid_o <= capture ? (st_n != ST_IDLE) : (state_q != ST_IDLE);
        end
    end

    interp_lerp #(.LOG2_OSR(LOG2_OSR), .IN_W(IN_W), .OUT_W(OUT_W)) u_lerp_i (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .capture    (capture),
        .force_zero (force_zero),
        .phase      (phase_q),
        .sym        (sym_i),
        .dac        (dac_i)
    );

    interp_lerp #(.LOG2_OSR(LOG2_OSR), .IN_W(IN_W), .OUT_W(OUT_W)) u_lerp_q (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .capture    (capture),
        .force_zero (force_zero),
        .phase      (phase_q),
        .sym        (sym_q),
        .dac        (dac_q)
    );

endmodule

// File: tb/tb_iq_interp_upsampler.sv
// tb/tb_iq_interp_upsampler.sv - self-checking bench for iq_interp_upsampler
module tb_iq_interp_upsampler;

    localparam int OSR = 8;

    logic               CLK = 1'b0;
    logic               RST;
    logic               en;
    logic               ce_sym;
    logic signed [10:0] xr_i;
    logic signed [10:0] xi_i;
    logic               valid_i;
    logic signed [10:0] dac_i;
    logic signed [10:0] dac_q;
    logic               valid_o;

    always #5 CLK = ~CLK;

    iq_interp_upsampler #(.LOG2_OSR(3), .IN_W(11), .OUT_W(11)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .en      (en),
        .ce_sym  (ce_sym),
        .xr_i    (xr_i),
        .xi_i    (xi_i),
        .valid_i (valid_i),
        .dac_i   (dac_i),
        .dac_q   (dac_q),
        .valid_o (valid_o)
    );

    int n_run;
    int n_fail;

    // Reference: each symbol period has a target (x if valid else 0); samples walk
    // linearly from the previous target to the current one; output is valid when
    // either of the last two captures carried a valid symbol.
    int m_phase;
    int m_tprev_i, m_tcur_i, m_tprev_q, m_tcur_q;
    bit m_vprev, m_vcur;
    int exp_i, exp_q;
    bit exp_v;

    typedef struct {
        bit e;
        bit v;
        int xr;
        int exp_i;
        bit exp_v;
    } vec_t;
    vec_t tbl[24];

    function automatic int lerp(input int a, input int b, input int k);
        int num, q;
        num = (b - a) * k;
        q   = num / OSR;
        if (num < 0 && (num % OSR) != 0) q = q - 1;
        return a + q;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_tprev_i = 0; m_tcur_i = 0; m_tprev_q = 0; m_tcur_q = 0;
        m_vprev = 0; m_vcur = 0;
        exp_i = 0; exp_q = 0; exp_v = 0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_run++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input bit e, input bit v, input int xr, input int xq, input string tag);
        @(negedge CLK);
        en = e; valid_i = v; xr_i = xr[10:0]; xi_i = xq[10:0];
        #1;
        chk({tag, "_ce_sym"}, int'(ce_sym), (e && m_phase == OSR-1) ? 1 : 0);
        @(posedge CLK);
        #1;
        if (e) begin
            if (m_phase == 0) begin
                m_tprev_i = m_tcur_i; m_tcur_i = v ? xr : 0;
                m_tprev_q = m_tcur_q; m_tcur_q = v ? xq : 0;
                m_vprev = m_vcur; m_vcur = v;
            end
            exp_i = lerp(m_tprev_i, m_tcur_i, m_phase);
            exp_q = lerp(m_tprev_q, m_tcur_q, m_phase);
            exp_v = m_vprev || m_vcur;
            m_phase = (m_phase + 1) % OSR;
        end
        chk({tag, "_dac_i"}, int'(dac_i), exp_i);
        chk({tag, "_dac_q"}, int'(dac_q), exp_q);
        chk({tag, "_valid_o"}, int'(valid_o), int'(exp_v));
    endtask

    initial begin
        int seq3[4];
        int ecount;
        n_run = 0; n_fail = 0;
        RST = 1'b0; en = 1'b0; valid_i = 1'b0; xr_i = '0; xi_i = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_dac_i", int'(dac_i), 0);
        chk("reset_dac_q", int'(dac_q), 0);
        chk("reset_valid_o", int'(valid_o), 0);
        chk("reset_ce_sym", int'(ce_sym), 0);
        @(negedge CLK);
        RST = 1'b1;

        // 1: idle with en held high, ce_sym every OSR cycles
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            en = 1'b1; valid_i = 1'b0;
            #1;
            chk("t1_ce_period", int'(ce_sym), (c % OSR == OSR-1) ? 1 : 0);
            @(posedge CLK);
            #1;
            m_phase = (m_phase + 1) % OSR;
            chk("t1_dac_i", int'(dac_i), 0);
            chk("t1_valid_o", int'(valid_o), 0);
        end

        // 2: single +8 symbol, table of hand-derived samples
        for (int k = 0; k < 8; k++) begin
            tbl[k]      = '{e: 1'b1, v: 1'b1, xr: 8, exp_i: k,     exp_v: 1'b1};
            tbl[8 + k]  = '{e: 1'b1, v: 1'b0, xr: 0, exp_i: 8 - k, exp_v: 1'b1};
            tbl[16 + k] = '{e: 1'b1, v: 1'b0, xr: 0, exp_i: 0,     exp_v: 1'b0};
        end
        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].e, tbl[i].v, tbl[i].xr, 0, "t2");
            chk("t2_tbl_dac_i", int'(dac_i), tbl[i].exp_i);
            chk("t2_tbl_valid_o", int'(valid_o), int'(tbl[i].exp_v));
        end

        // 3: burst +8,-8,-8,+8 then drain and idle
        seq3[0] = 8; seq3[1] = -8; seq3[2] = -8; seq3[3] = 8;
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < OSR; k++) begin
                cyc(1'b1, s < 4, (s < 4) ? seq3[s] : 0, 0, "t3");
                if (s == 1) chk("t3_p8_to_m8", int'(dac_i), 8 - 2*k);
                if (s == 2) chk("t3_const_m8", int'(dac_i), -8);
                if (s == 3) chk("t3_m8_to_p8", int'(dac_i), -8 + 2*k);
            end
        end

        // 4: en at 1-in-3 duty during a one-symbol burst plus a burst of two
        ecount = 0;
        for (int c = 0; c < 3 * 40; c++) begin
            bit e;
            e = (c % 3 == 0);
            cyc(e, (ecount < 8) || (ecount >= 24 && ecount < 40),
                (ecount < 24) ? 8 : ((ecount < 32) ? -100 : 37), 5, "t4");
            if (e) ecount++;
        end

        // 5: async reset mid-ramp
        for (int c = 0; c < 8 - m_phase + 3; c++) cyc(1'b1, 1'b1, 100, -50, "t5a");
        #2;
        en = 1'b0;
        RST = 1'b0;
        #1;
        chk("t5_async_dac_i", int'(dac_i), 0);
        chk("t5_async_dac_q", int'(dac_q), 0);
        chk("t5_async_valid_o", int'(valid_o), 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cyc(1'b1, c < 8, 16, -16, "t5b");
            if (c < 8) chk("t5_restart_ramp", int'(dac_i), 2*c);
        end

        // 6: valid drops for one symbol then returns (DRAIN->RUN)
        for (int c = 0; c < 48; c++) begin
            cyc(1'b1, !(c >= 8 && c < 16) && c < 24, (c < 8) ? 200 : -300, 64, "t6");
            if (c < 32) chk("t6_valid_held", int'(valid_o), 1);
        end

        // Random: random en, random valid/data every cycle (only phase 0 matters)
        for (int c = 0; c < 3000; c++) begin
            int xr, xq;
            xr = int'($urandom_range(0, 2047)) - 1024;
            xq = int'($urandom_range(0, 2047)) - 1024;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, xr, xq, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
